// File: rtl/rtc_bus_reader.sv
// Read-cycle sequencer for the RTC's multiplexed 8-bit address/data bus.
// Every output is registered from the next state, so pins change cleanly on the state-change edge.
module rtc_bus_reader #(
  parameter int PHASE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] addr,
  input  logic [7:0] ad_in,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  output logic       cs_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic       a_d,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    TURN,
    READ,
    RECOVER
  } state_t;

  localparam logic [3:0] LAST = 4'(PHASE_CYCLES - 1);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] cnt;
  logic       phase_done;
  logic       capture;

  assign phase_done = (cnt == LAST);

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    case (state)
      IDLE:    if (start) state_nxt = ADDR;
      ADDR:    if (phase_done) state_nxt = TURN;
      TURN:    state_nxt = READ;
      READ: begin
        if (phase_done) begin
          state_nxt = RECOVER;
          capture   = 1'b1;
        end
      end
      RECOVER: if (phase_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      ad_out     <= 8'h00;
      ad_oe      <= 1'b0;
      cs_n       <= 1'b1;
      rd_n       <= 1'b1;
      wr_n       <= 1'b1;
      a_d        <= 1'b1;
      data_out   <= 8'h00;
      data_valid <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state <= state_nxt;
      // Counter restarts on every state entry; TURN is one cycle regardless of it.
      if (state_nxt != state || state == IDLE) cnt <= 4'd0;
      else                                     cnt <= cnt + 4'd1;
      if (state == IDLE && start) ad_out <= addr;
      ad_oe      <= (state_nxt == ADDR);
      a_d        <= (state_nxt != ADDR);
      cs_n       <= !(state_nxt == ADDR || state_nxt == TURN || state_nxt == READ);
      rd_n       <= (state_nxt != READ);
      wr_n       <= 1'b1;
      if (capture) data_out <= ad_in;
      data_valid <= capture;
      busy       <= (state_nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_rtc_bus_reader.sv
// Bench for rtc_bus_reader: P=4 and P=1 instances share inputs, each checked every cycle against a timing model.
module tb_rtc_bus_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] addr  = 8'h00;
  logic [7:0] ad_in = 8'h00;

  logic [7:0] ad_out4, data_out4, ad_out1, data_out1;
  logic       ad_oe4, cs_n4, rd_n4, wr_n4, a_d4, data_valid4, busy4;
  logic       ad_oe1, cs_n1, rd_n1, wr_n1, a_d1, data_valid1, busy1;

  rtc_bus_reader #(.PHASE_CYCLES(4)) dut4 (
    .clk(clk), .reset(reset), .start(start), .addr(addr), .ad_in(ad_in),
    .ad_out(ad_out4), .ad_oe(ad_oe4), .cs_n(cs_n4), .rd_n(rd_n4), .wr_n(wr_n4),
    .a_d(a_d4), .data_out(data_out4), .data_valid(data_valid4), .busy(busy4)
  );

  rtc_bus_reader #(.PHASE_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .start(start), .addr(addr), .ad_in(ad_in),
    .ad_out(ad_out1), .ad_oe(ad_oe1), .cs_n(cs_n1), .rd_n(rd_n1), .wr_n(wr_n1),
    .a_d(a_d1), .data_out(data_out1), .data_valid(data_valid1), .busy(busy1)
  );

  // Packed view: [22:15] ad_out, 14 ad_oe, 13 cs_n, 12 rd_n, 11 wr_n, 10 a_d, [9:2] data_out, 1 data_valid, 0 busy
  logic [22:0] act4, act1;
  assign act4 = {ad_out4, ad_oe4, cs_n4, rd_n4, wr_n4, a_d4, data_out4, data_valid4, busy4};
  assign act1 = {ad_out1, ad_oe1, cs_n1, rd_n1, wr_n1, a_d1, data_out1, data_valid1, busy1};

  int n_cmp = 0;
  int n_err = 0;

  int         pp[2] = '{4, 1};
  int         k[2]  = '{0, 0};
  logic [7:0] lat[2];
  logic [7:0] dout[2];
  logic       pv[2];

  typedef struct {
    logic        rst;
    logic        st;
    logic [7:0]  a;
    logic [7:0]  din;
    logic [22:0] exp;
  } vec_t;

  function automatic logic [22:0] pk(logic [7:0] ao, logic oe, logic cs, logic rd, logic wr,
                                     logic adf, logic [7:0] d, logic v, logic b);
    return {ao, oe, cs, rd, wr, adf, d, v, b};
  endfunction

  // Expected pins from the cycle offset kk since the accepting edge (0 = idle).
  function automatic logic [22:0] model_out(int p, int kk, logic [7:0] la, logic [7:0] d);
    logic oe, cs, rd;
    oe = (kk >= 1 && kk <= p);
    cs = (kk >= 1 && kk <= 2*p + 1);
    rd = (kk >= p + 2 && kk <= 2*p + 1);
    return pk(la, oe, !cs, !rd, 1'b1, !oe, d, kk == 2*p + 2, kk != 0);
  endfunction

  function automatic logic [22:0] act_of(int i);
    return (i == 0) ? act4 : act1;
  endfunction

  task automatic chk(input string nm, input logic [22:0] a, input logic [22:0] e);
    n_cmp++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, a, e, $time);
    end
  endtask

  task automatic cyc();
    logic [22:0] a;
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        k[i] = 0; lat[i] = 8'h00; dout[i] = 8'h00;
      end else if (k[i] == 0) begin
        if (start) begin k[i] = 1; lat[i] = addr; end
      end else begin
        if (k[i] == 2*pp[i] + 1) dout[i] = ad_in;
        k[i] = (k[i] == 3*pp[i] + 1) ? 0 : k[i] + 1;
      end
      a = act_of(i);
      chk((i == 0) ? "model_p4" : "model_p1", a, model_out(pp[i], k[i], lat[i], dout[i]));
      chk((i == 0) ? "invariant_p4" : "invariant_p1",
          23'({a[11], a[14] & ~a[12], pv[i] & a[1]}), 23'(3'b100));
      pv[i] = a[1];
    end
  endtask

  vec_t tbl[6];
  int   pulses;

  initial begin
    pv[0] = 1'b0; pv[1] = 1'b0;
    lat[0] = 8'h00; lat[1] = 8'h00; dout[0] = 8'h00; dout[1] = 8'h00;

    // P=1 single read, row = inputs applied then the state seen after the next edge
    tbl[0] = '{1'b1, 1'b0, 8'h00, 8'h00, pk(8'h00, 0, 1, 1, 1, 1, 8'h00, 0, 0)};
    tbl[1] = '{1'b0, 1'b1, 8'h7F, 8'h12, pk(8'h7F, 1, 0, 1, 1, 0, 8'h00, 0, 1)};
    tbl[2] = '{1'b0, 1'b0, 8'h7F, 8'h12, pk(8'h7F, 0, 0, 1, 1, 1, 8'h00, 0, 1)};
    tbl[3] = '{1'b0, 1'b0, 8'h7F, 8'h12, pk(8'h7F, 0, 0, 0, 1, 1, 8'h00, 0, 1)};
    tbl[4] = '{1'b0, 1'b0, 8'h7F, 8'h12, pk(8'h7F, 0, 1, 1, 1, 1, 8'h12, 1, 1)};
    tbl[5] = '{1'b0, 1'b0, 8'h7F, 8'h12, pk(8'h7F, 0, 1, 1, 1, 1, 8'h12, 0, 0)};
    for (int r = 0; r < 6; r++) begin
      reset = tbl[r].rst; start = tbl[r].st; addr = tbl[r].a; ad_in = tbl[r].din;
      cyc();
      chk($sformatf("table_p1_row%0d", r), act1, tbl[r].exp);
    end
    for (int c = 0; c < 20; c++) cyc();

    // Single read, P=4
    start = 1'b1; addr = 8'h21; ad_in = 8'h59;
    for (int c = 1; c <= 14; c++) begin
      cyc();
      start = 1'b0;
      if (c <= 4) chk("single_addr_phase", 23'({ad_oe4, ad_out4}), 23'({1'b1, 8'h21}));
      if (c >= 6 && c <= 9) chk("single_rd_low", 23'(rd_n4), 23'(0));
      if (c == 10) chk("single_valid", 23'({data_valid4, data_out4}), 23'({1'b1, 8'h59}));
      if (c == 14) chk("single_busy_fall", 23'(busy4), 23'(0));
    end
    for (int c = 0; c < 4; c++) cyc();

    // Capture point: only the last READ cycle's value lands
    start = 1'b1; addr = 8'h44; ad_in = 8'hAA;
    for (int c = 1; c <= 14; c++) begin
      cyc();
      start = 1'b0;
      if (c == 9) ad_in = 8'h3C;
      if (c == 10) chk("capture_point", 23'(data_out4), 23'(8'h3C));
    end
    for (int c = 0; c < 4; c++) cyc();

    // Start while busy is ignored
    start = 1'b1; addr = 8'h21; pulses = 0;
    for (int c = 1; c <= 20; c++) begin
      cyc();
      start = (c == 3);
      if (c == 3) addr = 8'h05;
      if (data_valid4) pulses++;
      if (c == 10) chk("ignored_start_addr", 23'(ad_out4), 23'(8'h21));
    end
    chk("ignored_start_pulses", 23'(pulses), 23'(1));

    // Start held high: relaunch at cycle 15
    start = 1'b1; addr = 8'h33;
    for (int c = 1; c <= 15; c++) begin
      cyc();
      if (c == 14) chk("held_busy_gap", 23'(busy4), 23'(0));
      if (c == 15) chk("held_relaunch", 23'({ad_oe4, cs_n4, busy4, ad_out4}), 23'({3'b101, 8'h33}));
    end
    start = 1'b0;
    for (int c = 0; c < 16; c++) cyc();

    // Reset mid-read
    start = 1'b1; addr = 8'h21; ad_in = 8'h77; pulses = 0;
    for (int c = 1; c <= 16; c++) begin
      cyc();
      start = 1'b0;
      if (c >= 8 && data_valid4) pulses++;
      if (c == 7) reset = 1'b1;
      if (c == 8) begin
        chk("reset_mid_read", act4, pk(8'h00, 0, 1, 1, 1, 1, 8'h00, 0, 0));
        reset = 1'b0;
      end
    end
    chk("reset_no_valid", 23'(pulses), 23'(0));

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 199) == 0);
      start = ($urandom_range(0, 3) == 0);
      addr  = 8'($urandom);
      ad_in = 8'($urandom);
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
